// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// uart_receiver
// Recovers start / DATA_WIDTH data bits (LSB first) / stop frames from a serial line.
// The line is oversampled at OVERSAMPLE baudTick strobes per bit, and each bit is
// sampled at its mid-point.
//
// Ports
//   clk       system clock, all state on posedge
//   rstN      asynchronous active-low reset
//   baudTick  1-cycle strobe at OVERSAMPLE x baud rate
//   rx        serial line, idle high
//   dataOut   last good received word, held between frames
//   rxReady   1-cycle pulse when dataOut has just been updated
//   frameErr  1-cycle pulse when the stop bit is sampled low
//
// Build option
//   UART_RX_SYNC_EN  when defined, rx passes through a 2-flop synchronizer (reset
//                    to 1) before the FSM. Use it whenever rx is asynchronous to clk.
//                    Decoded data is the same either way. Only the latency changes.

module uart_receiver #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  baudTick,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  rxReady,
    output logic                  frameErr
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } stateT;

    stateT                 state;
    stateT                 stateNext;
    logic [TICK_W-1:0]     tickCnt;
    logic [TICK_W-1:0]     tickCntNext;
    logic [BIT_W-1:0]      bitCnt;
    logic [BIT_W-1:0]      bitCntNext;
    logic [DATA_WIDTH-1:0] shiftReg;
    logic [DATA_WIDTH-1:0] shiftNext;
    logic [DATA_WIDTH-1:0] dataOutNext;
    logic                  rxReadyNext;
    logic                  frameErrNext;
    logic                  rxLine;

`ifdef UART_RX_SYNC_EN
    // Two-flop synchronizer. It resets to the idle level so that reset release
    // cannot be mistaken for a start edge.
    logic [1:0] rxSync;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rxSync <= 2'b11;
        end else begin
            rxSync <= {rxSync[0], rx};
        end
    end

    assign rxLine = rxSync[1];
`else
    assign rxLine = rx;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            tickCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            dataOut  <= '0;
            rxReady  <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            state    <= stateNext;
            tickCnt  <= tickCntNext;
            bitCnt   <= bitCntNext;
            shiftReg <= shiftNext;
            dataOut  <= dataOutNext;
            rxReady  <= rxReadyNext;
            frameErr <= frameErrNext;
        end
    end

    // Next-state and output logic. Counters only move on baudTick cycles.
    always_comb begin
        stateNext    = state;
        tickCntNext  = tickCnt;
        bitCntNext   = bitCnt;
        shiftNext    = shiftReg;
        dataOutNext  = dataOut;
        rxReadyNext  = 1'b0;
        frameErrNext = 1'b0;

        unique case (state)
            // A falling edge is detected on any clk. Bit timing then starts from the tick grid.
            IDLE: begin
                if (!rxLine) begin
                    stateNext   = START;
                    tickCntNext = '0;
                end
            end

            // Confirm the start bit at its mid-point, so that short glitches are rejected.
            START: begin
                if (baudTick) begin
                    if (tickCnt == TICK_MID) begin
                        tickCntNext = '0;
                        if (!rxLine) begin
                            stateNext  = DATA;
                            bitCntNext = '0;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        tickCntNext = tickCnt + TICK_W'(1);
                    end
                end
            end

            // From the start-bit mid-point, a full bit period lands on each data bit's mid-point.
            DATA: begin
                if (baudTick) begin
                    if (tickCnt == TICK_LAST) begin
                        shiftNext   = {rxLine, shiftReg[DATA_WIDTH-1:1]};
                        bitCntNext  = bitCnt + BIT_W'(1);
                        tickCntNext = '0;
                        if (bitCnt == BIT_LAST) begin
                            stateNext = STOP;
                        end
                    end else begin
                        tickCntNext = tickCnt + TICK_W'(1);
                    end
                end
            end

            // Sample the stop bit. A low stop bit drops the word and parks the FSM in BREAK_WAIT.
            STOP: begin
                if (baudTick) begin
                    if (tickCnt == TICK_LAST) begin
                        tickCntNext = '0;
                        if (rxLine) begin
                            dataOutNext = shiftReg;
                            rxReadyNext = 1'b1;
                            stateNext   = IDLE;
                        end else begin
                            frameErrNext = 1'b1;
                            stateNext    = BREAK_WAIT;
                        end
                    end else begin
                        tickCntNext = tickCnt + TICK_W'(1);
                    end
                end
            end

            // A held-low line must return high before another frame is accepted.
            BREAK_WAIT: begin
                if (rxLine) begin
                    stateNext = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// tb_uart_receiver
// Directed bench for uart_receiver. The bench bit-bangs frames onto rx from a bench-side
// baudTick generator. The tick divider is programmable: with a divider of 1 the tick fires
// on every clk, which makes frame latency exact.

module tb_uart_receiver;

    localparam int unsigned DW = 8;
    localparam int unsigned OS = 16;

    // Latency from the negedge where rx falls to the negedge where rxReady is seen high.
    // Measured with baudTick high on every clk.
`ifdef UART_RX_SYNC_EN
    localparam int EXP_LAT = 155;
`else
    localparam int EXP_LAT = 153;
`endif

    logic          clk = 1'b0;
    logic          rstN;
    logic          baudTick = 1'b0;
    logic          rx;
    logic [DW-1:0] dataOut;
    logic          rxReady;
    logic          frameErr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int tickDiv = 1;
    int phase   = 0;
    int readyCnt = 0;
    int errCnt   = 0;
    int bothCnt  = 0;
    int readyCyc = 0;
    int lastStartCyc = 0;
    logic [7:0] rxQ[$];

    uart_receiver #(
        .DATA_WIDTH(DW),
        .OVERSAMPLE(OS)
    ) dut (
        .clk     (clk),
        .rstN    (rstN),
        .baudTick(baudTick),
        .rx      (rx),
        .dataOut (dataOut),
        .rxReady (rxReady),
        .frameErr(frameErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // baudTick changes 2ns after posedge, so it is stable at the next posedge.
    always @(posedge clk) begin
        #2;
        if (tickDiv <= 1) begin
            baudTick = 1'b1;
        end else begin
            phase    = (phase + 1) % tickDiv;
            baudTick = (phase == 0);
        end
    end

    // Output monitor, sampled on negedge
    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            if (rxReady === 1'b1) begin
                readyCnt = readyCnt + 1;
                readyCyc = cyc;
                rxQ.push_back(dataOut);
            end
            if (frameErr === 1'b1) errCnt = errCnt + 1;
            if (rxReady === 1'b1 && frameErr === 1'b1) bothCnt = bothCnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int bitClks();
        return OS * ((tickDiv < 1) ? 1 : tickDiv);
    endfunction

    // Callers enter and leave these tasks at a negedge.
    task automatic sendBit(input logic b);
        rx = b;
        repeat (bitClks()) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit);
        lastStartCyc = cyc;
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
        sendBit(stopBit);
    endtask

    logic [7:0] t2Bytes [12] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80,
                                 8'h7E, 8'hC3, 8'h3C, 8'h96, 8'h0F, 8'hF0};

    initial begin
        int r0;
        int e0;

        // T0: reset values
        rstN = 1'b0;
        rx   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dataOut", 32'(dataOut), 32'h00);
        check("reset_rxReady", 32'(rxReady), 32'h0);
        check("reset_frameErr", 32'(frameErr), 32'h0);
        rstN = 1'b1;
        repeat (4) @(negedge clk);

        // T1: single frame 0xA5 with tick every clk, so latency is exact
        r0 = readyCnt; e0 = errCnt;
        sendFrame(8'hA5, 1'b1);
        sendBit(1'b1);
        check("t1_ready_count", 32'(readyCnt - r0), 32'd1);
        check("t1_data", 32'(dataOut), 32'hA5);
        check("t1_frameErr", 32'(errCnt - e0), 32'd0);
        check("t1_latency", 32'(readyCyc - lastStartCyc), 32'(EXP_LAT));

        // T2: back-to-back frames with no idle gap, at a slower tick rate
        tickDiv = 3;
        repeat (10) @(negedge clk);
        rxQ.delete();
        r0 = readyCnt; e0 = errCnt;
        for (int i = 0; i < 12; i++) sendFrame(t2Bytes[i], 1'b1);
        sendBit(1'b1);
        sendBit(1'b1);
        check("t2_ready_count", 32'(readyCnt - r0), 32'd12);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t2_byte%0d", i),
                  (i < rxQ.size()) ? 32'(rxQ[i]) : 32'hDEAD, 32'(t2Bytes[i]));
        end
        check("t2_frameErr", 32'(errCnt - e0), 32'd0);

        // T3: start glitch of OVERSAMPLE/4 ticks is rejected
        r0 = readyCnt; e0 = errCnt;
        rx = 1'b0;
        repeat (4 * tickDiv) @(negedge clk);
        rx = 1'b1;
        repeat (2 * bitClks()) @(negedge clk);
        check("t3_no_ready", 32'(readyCnt - r0), 32'd0);
        check("t3_no_frameErr", 32'(errCnt - e0), 32'd0);
        check("t3_data_held", 32'(dataOut), 32'hF0);

        // T4: low stop bit, then line held low for 3 bit times, then a good frame
        r0 = readyCnt; e0 = errCnt;
        sendFrame(8'h3C, 1'b0);
        repeat (3 * bitClks()) @(negedge clk);
        rx = 1'b1;
        repeat (bitClks()) @(negedge clk);
        check("t4_frameErr_count", 32'(errCnt - e0), 32'd1);
        check("t4_no_ready", 32'(readyCnt - r0), 32'd0);
        check("t4_data_held", 32'(dataOut), 32'hF0);
        r0 = readyCnt;
        sendFrame(8'h81, 1'b1);
        sendBit(1'b1);
        check("t4_after_ready", 32'(readyCnt - r0), 32'd1);
        check("t4_after_data", 32'(dataOut), 32'h81);

        // T5: reset in the middle of data bit 4, then a good frame
        r0 = readyCnt; e0 = errCnt;
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b0);
        rx = 1'b0;
        repeat (bitClks() / 2) @(negedge clk);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_rst_dataOut", 32'(dataOut), 32'h00);
        check("t5_rst_rxReady", 32'(rxReady), 32'h0);
        check("t5_rst_frameErr", 32'(frameErr), 32'h0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (2 * bitClks()) @(negedge clk);
        check("t5_abort_no_ready", 32'(readyCnt - r0), 32'd0);
        check("t5_abort_no_err", 32'(errCnt - e0), 32'd0);
        sendFrame(8'h5A, 1'b1);
        sendBit(1'b1);
        check("t5_ready_count", 32'(readyCnt - r0), 32'd1);
        check("t5_data", 32'(dataOut), 32'h5A);

        check("ready_err_overlap", 32'(bothCnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
